regfile_mp_sb: RTL and testbench

//  Parametrised multi-read-port register file for the pipelined CPU, with an integrated scoreboard.

---
 rtl/regfile_mp_sb_pkg.sv | 9 +
 rtl/regfile_mp_sb_if.sv | 35 +++
 rtl/regfile_mp_sb_scoreboard.sv | 38 +++
 rtl/regfile_mp_sb.sv | 70 +++++++
 tb/tb_regfile_mp_sb.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the ID/WB register file and its scoreboard.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width used by
//                             the ID and WB stages.
//   REG_ZERO                : address of the hard-wired zero register.
package regfile_mp_sb_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus between the ID/WB stages and the register file.
//   rd_addr  : NRD packed read addresses (port k = [k*ADDR_W +: ADDR_W])
//   rd_data  : NRD packed read data      (port k = [k*DATA_W +: DATA_W])
//   rd_busy  : per-port pending-producer flag
//   wt_en/wt_addr/wt_data : writeback
//   iss_en/iss_addr       : issue of an instruction with a destination
//   hazard   : OR of rd_busy
// master = pipeline side, slave = register file side.
interface regfile_mp_sb_if
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wt_en;
  logic [ADDR_W-1:0]     wt_addr;
  logic [DATA_W-1:0]     wt_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  hazard;

  modport master (
    output rd_addr, wt_en, wt_addr, wt_data, iss_en, iss_addr,
    input  rd_data, rd_busy, hazard
  );

  modport slave (
    input  rd_addr, wt_en, wt_addr, wt_data, iss_en, iss_addr,
    output rd_data, rd_busy, hazard
  );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register.
//   clk, rst           : clock, asynchronous active-high reset
//   iss_en, iss_addr   : set busy[iss_addr]
//   wt_en, wt_addr     : clear busy[wt_addr]
//   busy               : full busy vector (2**ADDR_W bits)
module regfile_mp_sb_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   wt_en,
  input  logic [ADDR_W-1:0]      wt_addr,
  output logic [(1<<ADDR_W)-1:0] busy
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (wt_en) busy_nxt[wt_addr] = 1'b0;
    // Set is applied after clear: a same-address issue means a newer
    // producer is already in flight and must keep the register busy.
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG) busy_nxt[ZADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass and busy scoreboard.
//   clk, rst : clock, asynchronous active-high reset (clears data and busy)
//   bus      : regfile_mp_sb_if slave port (read ports, writeback, issue, hazard)
// Parameters: DATA_W, ADDR_W, NRD (1..4), ZERO_REG, BYPASS.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_sb_if.slave bus
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]           mem [DEPTH];
  logic [DEPTH-1:0]            busy;
  logic                        wt_ok;
  logic [NRD-1:0][DATA_W-1:0]  rd_data_w;
  logic [NRD-1:0]              rd_busy_w;

  assign wt_ok = bus.wt_en && !(ZERO_REG && (bus.wt_addr == ZADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wt_ok) begin
      mem[bus.wt_addr] <= bus.wt_data;
    end
  end

  regfile_mp_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wt_en    (bus.wt_en),
    .wt_addr  (bus.wt_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              fwd;

    assign a       = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && (a == ZADDR);
    // Forwarding is suppressed during reset so outputs stay 0 even if the
    // writeback port is active while rst is held.
    assign fwd     = BYPASS && !rst && bus.wt_en && (bus.wt_addr == a);

    assign rd_data_w[k] = (rst || is_zero) ? '0 :
                          fwd              ? bus.wt_data : mem[a];
    // A forwarded value is no longer pending from the reader's viewpoint.
    assign rd_busy_w[k] = !rst && !fwd && busy[a];
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;
  assign bus.hazard  = |rd_busy_w;
endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
  localparam int SEL_HAZ = 99;

  typedef struct {
    string       tag;
    int          dut;
    int          sel;
    logic [63:0] val;
  } exp_t;

  logic clk, rst;

  // Bench-side drive values: index 0 = dut_a, 1 = dut_b, 2 = dut_c
  logic        dr_wen   [3];
  logic [4:0]  dr_waddr [3];
  logic [63:0] dr_wdata [3];
  logic        dr_iss   [3];
  logic [4:0]  dr_iaddr [3];
  logic [4:0]  dr_raddr [3][4];

  // Reference model state
  logic [63:0] m_mem  [3][32];
  logic [31:0] m_busy [3];
  bit          zr [3];
  bit          bp [3];
  int          np [3];

  exp_t sbq[$];
  int   n_chk, n_fail;

  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_a ();
  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_b ();
  regfile_mp_sb_if #(.DATA_W(64), .ADDR_W(5), .NRD(4)) bus_c ();

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  regfile_mp_sb #(.DATA_W(64), .ADDR_W(5), .NRD(4), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_a.rd_addr  = {dr_raddr[0][1], dr_raddr[0][0]};
  assign bus_a.wt_en    = dr_wen[0];
  assign bus_a.wt_addr  = dr_waddr[0];
  assign bus_a.wt_data  = dr_wdata[0][31:0];
  assign bus_a.iss_en   = dr_iss[0];
  assign bus_a.iss_addr = dr_iaddr[0];

  assign bus_b.rd_addr  = {dr_raddr[1][1], dr_raddr[1][0]};
  assign bus_b.wt_en    = dr_wen[1];
  assign bus_b.wt_addr  = dr_waddr[1];
  assign bus_b.wt_data  = dr_wdata[1][31:0];
  assign bus_b.iss_en   = dr_iss[1];
  assign bus_b.iss_addr = dr_iaddr[1];

  assign bus_c.rd_addr  = {dr_raddr[2][3], dr_raddr[2][2], dr_raddr[2][1], dr_raddr[2][0]};
  assign bus_c.wt_en    = dr_wen[2];
  assign bus_c.wt_addr  = dr_waddr[2];
  assign bus_c.wt_data  = dr_wdata[2];
  assign bus_c.iss_en   = dr_iss[2];
  assign bus_c.iss_addr = dr_iaddr[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] obs_val(int d, int sel);
    int k;
    k = sel / 2;
    case (d)
      0: begin
        if (sel == SEL_HAZ)   return {63'd0, bus_a.hazard};
        else if (sel % 2 == 0) return {32'd0, bus_a.rd_data[k*32 +: 32]};
        else                  return {63'd0, bus_a.rd_busy[k]};
      end
      1: begin
        if (sel == SEL_HAZ)   return {63'd0, bus_b.hazard};
        else if (sel % 2 == 0) return {32'd0, bus_b.rd_data[k*32 +: 32]};
        else                  return {63'd0, bus_b.rd_busy[k]};
      end
      default: begin
        if (sel == SEL_HAZ)   return {63'd0, bus_c.hazard};
        else if (sel % 2 == 0) return bus_c.rd_data[k*64 +: 64];
        else                  return {63'd0, bus_c.rd_busy[k]};
      end
    endcase
  endfunction

  function automatic logic [63:0] exp_data(int d, int k);
    logic [4:0] a;
    a = dr_raddr[d][k];
    if (rst) return 64'd0;
    if (zr[d] && a == 5'd0) return 64'd0;
    if (bp[d] && dr_wen[d] && dr_waddr[d] == a) return dr_wdata[d];
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(int d, int k);
    logic [4:0] a;
    a = dr_raddr[d][k];
    if (rst) return 1'b0;
    if (bp[d] && dr_wen[d] && dr_waddr[d] == a) return 1'b0;
    return m_busy[d][a];
  endfunction

  function automatic logic [63:0] wide_val(int a);
    if (a == 0) return 64'd0;
    return 64'(a) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic push(string tag, int d, int sel, logic [63:0] val);
    exp_t e;
    e.tag = tag; e.dut = d; e.sel = sel; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic push_all(int d, string tag);
    logic hz;
    hz = 1'b0;
    for (int k = 0; k < np[d]; k++) begin
      push($sformatf("%s_dut%0d_data%0d", tag, d, k), d, 2*k, exp_data(d, k));
      push($sformatf("%s_dut%0d_busy%0d", tag, d, k), d, 2*k+1, {63'd0, exp_busy(d, k)});
      hz = hz | exp_busy(d, k);
    end
    push($sformatf("%s_dut%0d_hazard", tag, d), d, SEL_HAZ, {63'd0, hz});
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 32; i++) m_mem[d][i] = 64'd0;
      m_busy[d] = 32'd0;
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 3; d++) begin
      dr_wen[d] = 1'b0; dr_waddr[d] = 5'd0; dr_wdata[d] = 64'd0;
      dr_iss[d] = 1'b0; dr_iaddr[d] = 5'd0;
      for (int k = 0; k < 4; k++) dr_raddr[d][k] = 5'd0;
    end
  endtask

  task automatic model_update(int d);
    if (dr_wen[d] && !(zr[d] && dr_waddr[d] == 5'd0)) m_mem[d][dr_waddr[d]] = dr_wdata[d];
    if (dr_wen[d]) m_busy[d][dr_waddr[d]] = 1'b0;
    if (dr_iss[d] && !(zr[d] && dr_iaddr[d] == 5'd0)) m_busy[d][dr_iaddr[d]] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) for (int d = 0; d < 3; d++) model_update(d);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [63:0] got;
    for (int d = 0; d < 3; d++) begin
      dr_wen[d] = 1'b1; dr_waddr[d] = 5'd3; dr_wdata[d] = 64'h99;
      dr_iss[d] = 1'b1; dr_iaddr[d] = 5'd3;
      for (int k = 0; k < 4; k++) dr_raddr[d][k] = 5'd3;
    end
    for (int c = 0; c < 34; c++) begin
      if (c == 2) begin rst = 1'b0; clear_inputs(); end
      if (c >= 2)
        for (int d = 0; d < 3; d++)
          for (int k = 0; k < 4; k++) dr_raddr[d][k] = 5'((c - 2 + k) % 32);
      if (c < 2) push("reset_hold_data0", 0, 0, 64'd0);
      for (int d = 0; d < 3; d++) push_all(d, "reset");
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [63:0] got;
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        dr_wen[d] = (c == 0); dr_waddr[d] = 5'd5; dr_wdata[d] = 64'hDEAD_BEEF;
        dr_raddr[d][0] = 5'd5; dr_raddr[d][1] = 5'd6;
      end
      push("bypass_a_r5", 0, 0, 64'hDEAD_BEEF);
      push("nobypass_b_r5", 1, 0, (c == 0) ? 64'd0 : 64'hDEAD_BEEF);
      push_all(0, "bypass"); push_all(1, "bypass");
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    exp_t e; logic [63:0] got;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      if (c == 0)
        for (int d = 0; d < 2; d++) begin
          dr_wen[d] = 1'b1; dr_waddr[d] = 5'd0; dr_wdata[d] = 64'h1234;
          dr_iss[d] = 1'b1; dr_iaddr[d] = 5'd0;
        end
      if (c == 2) begin dr_wen[1] = 1'b1; dr_waddr[1] = 5'd0; dr_wdata[1] = 64'h1234; end
      push("zero_a_data", 0, 0, 64'd0);
      push("zero_a_busy", 0, 1, 64'd0);
      if (c == 1) begin
        push("nozero_b_data", 1, 0, 64'h1234);
        push("nozero_b_busy", 1, 1, 64'd1);
      end
      if (c == 3) push("nozero_b_busy_cleared", 1, 1, 64'd0);
      push_all(0, "zero"); push_all(1, "zero");
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_issue_wb();
    exp_t e; logic [63:0] got;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      dr_raddr[0][0] = 5'd5; dr_raddr[0][1] = 5'd7;
      if (c == 0) begin dr_iss[0] = 1'b1; dr_iaddr[0] = 5'd7; end
      if (c == 2) begin dr_wen[0] = 1'b1; dr_waddr[0] = 5'd7; dr_wdata[0] = 64'h55; end
      case (c)
        0: push("iss_busy1_same_cycle", 0, 3, 64'd0);
        1: begin
          push("iss_busy1", 0, 3, 64'd1);
          push("iss_hazard", 0, SEL_HAZ, 64'd1);
        end
        2: begin
          push("wb_fwd_busy1", 0, 3, 64'd0);
          push("wb_fwd_data1", 0, 2, 64'h55);
          push("wb_fwd_hazard", 0, SEL_HAZ, 64'd0);
        end
        default: begin
          push("wb_after_busy1", 0, 3, 64'd0);
          push("wb_after_data1", 0, 2, 64'h55);
        end
      endcase
      push_all(0, "isswb");
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_set_clear();
    exp_t e; logic [63:0] got;
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      case (c)
        0: begin dr_iss[0] = 1'b1; dr_iaddr[0] = 5'd4; end
        1: begin
          dr_iss[0] = 1'b1; dr_iaddr[0] = 5'd9;
          dr_wen[0] = 1'b1; dr_waddr[0] = 5'd9; dr_wdata[0] = 64'hA;
        end
        2: begin
          dr_iss[0] = 1'b1; dr_iaddr[0] = 5'd3;
          dr_wen[0] = 1'b1; dr_waddr[0] = 5'd4; dr_wdata[0] = 64'h44;
        end
        3: begin
          dr_raddr[0][0] = 5'd9; dr_raddr[0][1] = 5'd3;
          push("setwins_r9_busy", 0, 1, 64'd1);
          push("setwins_r9_data", 0, 0, 64'hA);
          push("diff_r3_busy", 0, 3, 64'd1);
        end
        default: begin
          dr_raddr[0][0] = 5'd4; dr_raddr[0][1] = 5'd9;
          push("diff_r4_busy", 0, 1, 64'd0);
          push("diff_r4_data", 0, 0, 64'h44);
          push("setwins_r9_still_busy", 0, 3, 64'd1);
        end
      endcase
      push_all(0, "setclr");
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_wide();
    exp_t e; logic [63:0] got;
    // 0..31 fill, 32..39 concurrent reads, 40 mid-sequence reset,
    // 41 write right after release, 42 read back
    for (int c = 0; c < 43; c++) begin
      clear_inputs();
      if (c < 32) begin
        dr_wen[2] = 1'b1; dr_waddr[2] = 5'(c); dr_wdata[2] = 64'(c) * 64'h0101_0101_0101_0101;
        for (int k = 0; k < 4; k++) dr_raddr[2][k] = 5'(c);
        push($sformatf("wide_fill_r%0d", c), 2, 0, wide_val(c));
        push_all(2, "wide_fill");
        @(negedge clk);
      end else if (c < 40) begin
        dr_raddr[2][0] = 5'(c - 32);      dr_raddr[2][1] = 5'(c - 24);
        dr_raddr[2][2] = 5'(c - 16);      dr_raddr[2][3] = 5'(63 - c);
        for (int k = 0; k < 4; k++)
          push($sformatf("wide_read_p%0d_r%0d", k, dr_raddr[2][k]), 2, 2*k, wide_val(int'(dr_raddr[2][k])));
        push_all(2, "wide_read");
        @(negedge clk);
      end else if (c == 40) begin
        dr_wen[2] = 1'b1; dr_waddr[2] = 5'd12; dr_wdata[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 4; k++) dr_raddr[2][k] = 5'(12 + k);
        @(negedge clk);
        #1 rst = 1'b1;
        clear_model();
        #1;
        for (int k = 0; k < 4; k++) begin
          push($sformatf("midrst_data%0d", k), 2, 2*k, 64'd0);
          push($sformatf("midrst_busy%0d", k), 2, 2*k+1, 64'd0);
        end
        push("midrst_hazard", 2, SEL_HAZ, 64'd0);
      end else begin
        if (c == 41) begin
          rst = 1'b0;
          dr_wen[2] = 1'b1; dr_waddr[2] = 5'd3; dr_wdata[2] = 64'h77;
        end
        dr_raddr[2][0] = 5'd3; dr_raddr[2][1] = 5'd12;
        dr_raddr[2][2] = 5'd13; dr_raddr[2][3] = 5'd0;
        push("postrst_r3", 2, 0, 64'h77);
        push("postrst_r12_discarded", 2, 2, 64'd0);
        push("postrst_r13", 2, 4, 64'd0);
        push_all(2, "postrst");
        @(negedge clk);
      end
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [63:0] got;
    for (int c = 0; c < 80; c++) begin
      for (int d = 0; d < 3; d++) begin
        dr_wen[d]   = ($urandom_range(0, 1) == 1);
        dr_waddr[d] = 5'($urandom_range(0, 7));
        dr_wdata[d] = (d == 2) ? {32'($urandom), 32'($urandom)} : {32'd0, 32'($urandom)};
        dr_iss[d]   = ($urandom_range(0, 2) == 0);
        dr_iaddr[d] = 5'($urandom_range(0, 7));
        for (int k = 0; k < 4; k++) dr_raddr[d][k] = 5'($urandom_range(0, 7));
        if (c % 9 == 0) dr_raddr[d][1] = dr_raddr[d][0];
        push_all(d, $sformatf("b2b_c%0d", c));
      end
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); got = obs_val(e.dut, e.sel); n_chk++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: observed %h expected %h", e.tag, got, e.val);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    zr = '{1'b1, 1'b0, 1'b1};
    bp = '{1'b1, 1'b0, 1'b1};
    np = '{2, 2, 4};
    rst = 1'b1;
    clear_model();
    clear_inputs();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_issue_wb();
    test_set_clear();
    test_wide();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
